// File: rtl/sdi_delay_rx_if.sv
// Serial delay-chip lines (EN/SDIN/SCLK/SLOAD) plus the receiver's committed-word outputs.
// master drives the serial lines; slave is the receiver.
interface sdi_delay_rx_if #(
  parameter int N_CH   = 8,
  parameter int DATA_W = 11
);
  logic [N_CH-1:0]        EN;
  logic                   SDIN;
  logic                   SCLK;
  logic                   SLOAD;
  logic [N_CH*DATA_W-1:0] Dly_out;
  logic [N_CH-1:0]        Dly_valid;
  logic                   Frame_err;
  logic [1:0]             Err_code;
  logic                   Busy;

  modport master (
    output EN, SDIN, SCLK, SLOAD,
    input  Dly_out, Dly_valid, Frame_err, Err_code, Busy
  );
  modport slave (
    input  EN, SDIN, SCLK, SLOAD,
    output Dly_out, Dly_valid, Frame_err, Err_code, Busy
  );
endinterface

// File: rtl/sdi_delay_rx.sv
// Oversampling receiver for the NB6L295 serial delay interface; commits framed words to per-channel registers.
// Optional macro SDI_RX_ENCHECK_EN: reject multi-hot EN instead of broadcasting the word.
module sdi_delay_ch #(
  parameter int DATA_W = 11
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              we,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              vld
);
  always_ff @(posedge Clk) begin
    if (Reset) begin
      dout <= '0;
      vld  <= 1'b0;
    end else begin
      vld <= we;
      if (we) dout <= din;
    end
  end
endmodule

module sdi_delay_rx #(
  parameter int DATA_W   = 11,
  parameter int MAX_BITS = 12,
  parameter int N_CH     = 8
) (
  input logic           Clk,
  input logic           Reset,
  sdi_delay_rx_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD, HOLD} state_t;

  localparam logic [4:0] DW5 = 5'(DATA_W);
  localparam logic [4:0] MB5 = 5'(MAX_BITS);

  state_t                       state;
  logic [N_CH-1:0]              en_m, en_s, snap;
  logic                         sdin_m, sdin_s;
  logic                         sclk_m, sclk_s, sclk_d;
  logic                         sload_m, sload_s, sload_d;
  logic [1:0]                   settle;
  logic [4:0]                   cnt;
  logic [DATA_W-1:0]            sr;
  logic                         frame_err;
  logic [1:0]                   err_code;
  logic                         sclk_rise, sload_rise, len_ok, multi_rej;
  logic [N_CH-1:0]              sel, we, vld;
  logic [N_CH-1:0][DATA_W-1:0]  dly_q;

  assign sclk_rise  = sclk_s & ~sclk_d;
  assign sload_rise = sload_s & ~sload_d;
  assign sel        = ~snap;
  assign len_ok     = (cnt >= DW5) && (cnt <= MB5);

`ifdef SDI_RX_ENCHECK_EN
  assign multi_rej = ($countones(sel) > 1);
`else
  assign multi_rej = 1'b0;
`endif

  // Synchronizers reset to 0, which reads as "EN active"; settle keeps IDLE
  // from arming on that until real EN values have reached en_s.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      {en_m, en_s}       <= '0;
      {sdin_m, sdin_s}   <= '0;
      {sclk_m, sclk_s}   <= '0;
      {sload_m, sload_s} <= '0;
      sclk_d             <= 1'b0;
      sload_d            <= 1'b0;
      settle             <= '0;
    end else begin
      en_m    <= bus.EN;    en_s    <= en_m;
      sdin_m  <= bus.SDIN;  sdin_s  <= sdin_m;
      sclk_m  <= bus.SCLK;  sclk_s  <= sclk_m;
      sload_m <= bus.SLOAD; sload_s <= sload_m;
      sclk_d  <= sclk_s;
      sload_d <= sload_s;
      settle  <= {settle[0], 1'b1};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      snap      <= '1;
      cnt       <= '0;
      sr        <= '0;
      frame_err <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          sr  <= '0;
          if (settle[1] && !(&en_s) && !sload_s) begin
            snap  <= en_s;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (en_s != snap) begin
            frame_err <= 1'b1;
            err_code  <= 2'b10;
            state     <= IDLE;
          end else begin
            // A coincident SCLK edge is counted before moving to LOAD.
            if (sclk_rise) begin
              if (cnt < DW5) sr <= {sr[DATA_W-2:0], sdin_s};
              if (cnt != 5'd31) cnt <= cnt + 5'd1;
            end
            if (sload_rise) state <= LOAD;
          end
        end
        LOAD: begin
          if (!len_ok) begin
            frame_err <= 1'b1;
            err_code  <= 2'b01;
          end else if (multi_rej) begin
            frame_err <= 1'b1;
            err_code  <= 2'b11;
          end
          state <= HOLD;
        end
        HOLD: if (!sload_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign we = (state == LOAD && len_ok && !multi_rej) ? sel : '0;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    sdi_delay_ch #(.DATA_W(DATA_W)) u_ch (
      .Clk  (Clk),
      .Reset(Reset),
      .we   (we[k]),
      .din  (sr),
      .dout (dly_q[k]),
      .vld  (vld[k])
    );
  end

  assign bus.Dly_out   = dly_q;
  assign bus.Dly_valid = vld;
  assign bus.Frame_err = frame_err;
  assign bus.Err_code  = err_code;
  assign bus.Busy      = (state != IDLE);
endmodule
